// File: rtl/datafeed_sink.sv
// Datafeed stream consumer: tick edge detect, delayed sample capture, FWFT FIFO, valid/ready out.
// Define SEQ_CHECK_EN to build the captured-sequence checker (seq_err / err_count).
module datafeed_sink #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned CAPTURE_DLY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_in,
  input  logic [DATA_W-1:0]             data_in,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic                          seq_err,
  output logic [15:0]                   err_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StWait, StCap} state_e;

  state_e      state_q, state_d;
  logic [3:0]  dly_cnt_q, dly_cnt_d;
  logic        tick_d;
  logic        tick_edge;
  logic        cap;

  assign tick_edge = tick_in & ~tick_d;
  assign cap       = (state_q == StCap);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      dly_cnt_q <= '0;
      tick_d    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      tick_d    <= tick_in;
    end
  end

  // CAP is the cycle E+CAPTURE_DLY itself, so data_in is pushed straight into the FIFO there.
  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (tick_edge) begin
          dly_cnt_d = 4'(CAPTURE_DLY - 1);
          state_d   = (CAPTURE_DLY == 1) ? StCap : StWait;
        end
      end
      StWait: begin
        if (dly_cnt_q <= 4'd1) begin
          state_d = StCap;
        end else begin
          dly_cnt_d = dly_cnt_q - 4'd1;
        end
      end
      StCap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FWFT FIFO
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     count_q;
  logic              full, pop, push_ok, drop;

  assign full    = (count_q == LW'(FIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop     = out_valid & out_ready;
  assign push_ok = cap & (~full | pop);
  assign drop    = cap & full & ~pop;

  assign out_data   = out_valid ? mem[rd_ptr_q] : '0;
  assign fill_level = count_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef SEQ_CHECK_EN
  logic [DATA_W-1:0] prev_q;
  logic              prev_valid_q;
  logic              seq_err_q;
  logic [15:0]       err_cnt_q;
  logic [DATA_W-1:0] exp_inc, exp_alt;
  logic              mismatch;

  assign exp_inc  = prev_q + 1'b1;
  assign exp_alt  = (prev_q > DATA_W'(64)) ? '0 : DATA_W'(6);
  // Checked on every CAP, whether or not the FIFO accepted the sample.
  assign mismatch = cap & prev_valid_q & (data_in != exp_inc) & (data_in != exp_alt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      seq_err_q <= mismatch;
      if (cap) begin
        prev_q       <= data_in;
        prev_valid_q <= 1'b1;
      end
      if (mismatch && err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign seq_err   = seq_err_q;
  assign err_count = err_cnt_q;
`else
  assign seq_err   = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_datafeed_sink.sv
// Directed self-checking bench for datafeed_sink (default parameters, CAPTURE_DLY=2).
module tb_datafeed_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_in;
  logic [15:0] data_in;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  fill_level;
  logic        overflow;
  logic        clear_overflow;
  logic        seq_err;
  logic [15:0] err_count;

`ifdef SEQ_CHECK_EN
  localparam bit SeqOn = 1'b1;
`else
  localparam bit SeqOn = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  datafeed_sink #(
    .DATA_W      (16),
    .FIFO_DEPTH  (16),
    .CAPTURE_DLY (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tick_in        (tick_in),
    .data_in        (data_in),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .fill_level     (fill_level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .seq_err        (seq_err),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // One tick pulse; returns in cycle E+3, first cycle the sample can be seen at the head.
  task automatic send(input logic [15:0] v, input bit pop_at_cap);
    tick_in = 1'b1;
    data_in = v;
    cyc();
    tick_in = 1'b0;
    cyc();
    if (pop_at_cap) out_ready = 1'b1;
    cyc();
    if (pop_at_cap) out_ready = 1'b0;
  endtask

  task automatic drain(input int first, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_data", 32'(out_data), 32'(first + i));
      cyc();
    end
    out_ready = 1'b0;
    check("drain_empty_level", 32'(fill_level), 32'd0);
    check("drain_empty_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    tick_in        = 1'b0;
    data_in        = '0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    #2;
    check("rst_valid",    32'(out_valid),  32'd0);
    check("rst_data",     32'(out_data),   32'd0);
    check("rst_level",    32'(fill_level), 32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_seq_err",  32'(seq_err),    32'd0);
    check("rst_err_cnt",  32'(err_count),  32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    // 1: stream-through with out_ready held high
    out_ready = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      send(16'(i), 1'b0);
      check("t1_valid", 32'(out_valid),  32'd1);
      check("t1_data",  32'(out_data),   32'(i));
      check("t1_level", 32'(fill_level), 32'd1);
      cyc();
      check("t1_valid_gone", 32'(out_valid),  32'd0);
      check("t1_level_zero", 32'(fill_level), 32'd0);
    end
    out_ready = 1'b0;

    // 2: overfill by one, drain, clear overflow
    do_reset();
    for (int i = 1; i <= 17; i++) send(16'(i), 1'b0);
    check("t2_level_full", 32'(fill_level), 32'd16);
    check("t2_overflow",   32'(overflow),   32'd1);
    drain(1, 16);
    check("t2_overflow_sticky", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    cyc();
    clear_overflow = 1'b0;
    check("t2_overflow_clr", 32'(overflow), 32'd0);

    // 3: push into full FIFO while popping
    for (int i = 1; i <= 16; i++) send(16'(i), 1'b0);
    check("t3_level_full", 32'(fill_level), 32'd16);
    send(16'd17, 1'b1);
    check("t3_level_kept", 32'(fill_level), 32'd16);
    check("t3_no_overflow", 32'(overflow),  32'd0);
    drain(2, 16);

    // 4: second edge during CAP is ignored; data sampled at E+2
    do_reset();
    tick_in = 1'b1; data_in = 16'd40; cyc();
    tick_in = 1'b0; data_in = 16'd41; cyc();
    tick_in = 1'b1; data_in = 16'd42; cyc();
    tick_in = 1'b0; data_in = 16'd43; cyc();
    for (int i = 0; i < 5; i++) cyc();
    check("t4_level_one", 32'(fill_level), 32'd1);
    check("t4_data",      32'(out_data),   32'd42);
    drain(42, 1);

    // 5: sequence checker
    do_reset();
    out_ready = 1'b1;
    send(16'd63, 1'b0); check("t5_63", 32'(seq_err), 32'd0);
    send(16'd64, 1'b0); check("t5_64", 32'(seq_err), 32'd0);
    send(16'd6,  1'b0); check("t5_6",  32'(seq_err), 32'd0);
    send(16'd7,  1'b0); check("t5_7",  32'(seq_err), 32'd0);
    send(16'd9,  1'b0); check("t5_9",  32'(seq_err), 32'(SeqOn));
    check("t5_cnt_one", 32'(err_count), 32'(SeqOn));
    cyc();
    check("t5_pulse_end", 32'(seq_err), 32'd0);
    do_reset();
    send(16'd64, 1'b0); check("t5b_64", 32'(seq_err), 32'd0);
    send(16'd65, 1'b0); check("t5b_65", 32'(seq_err), 32'd0);
    send(16'd0,  1'b0); check("t5b_0",  32'(seq_err), 32'd0);
    check("t5b_cnt_zero", 32'(err_count), 32'd0);
    out_ready = 1'b0;
    cyc();

    // 6: reset mid-WAIT with entries queued
    do_reset();
    for (int i = 1; i <= 3; i++) send(16'(i), 1'b0);
    check("t6_level_three", 32'(fill_level), 32'd3);
    tick_in = 1'b1; data_in = 16'd99; cyc();
    tick_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid),  32'd0);
    check("t6_rst_level", 32'(fill_level), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("t6_no_late_cap", 32'(fill_level), 32'd0);
    send(16'd50, 1'b0);
    check("t6_after_valid", 32'(out_valid), 32'd1);
    check("t6_after_data",  32'(out_data),  32'd50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
